icache_dm: RTL and testbench

- Direct-mapped instruction cache between the fetch-stage PC (inst_adr) and a slower instruction memory that answers over a req/ack handshake.
- Supplies the 32-bit instruction word to the IF/ID register.
- Raises stall on a miss; the hazard unit ORs stall into PC/IF-ID hold (pc_load=0, IFID_Ld=0) until the line is refilled.

---
 rtl/icache_dm.sv | 131 +++++++++++++
 tb/tb_icache_dm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency lookup, line refill over a req/ack handshake.
// ICACHE_STATS_EN builds saturating hit/miss counters; otherwise hit_cnt/miss_cnt are tied to 0.
module icache_dm #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_adr,
  output logic [31:0] inst,
  output logic        hit,
  output logic        stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_adr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_data [LINES][LINE_WORDS];
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [LINES-1:0]   r_valid;
  logic [31:0]        r_base;
  logic [IDX_W-1:0]   r_idx;
  logic [OFF_W-1:0]   r_cnt;
  logic               r_abort;

  logic [OFF_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_miss_start;
  logic               w_ack;
  logic               w_last;
  logic               w_unused;

  assign w_off    = inst_adr[OFF_W+1:2];
  assign w_idx    = inst_adr[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag    = inst_adr[31:OFF_W+IDX_W+2];
  assign w_unused = &{1'b0, inst_adr[1:0]};

  assign w_hit        = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss_start = (r_state == S_IDLE) && !w_hit;
  // acks outside REFILL carry no request and are dropped
  assign w_ack        = (r_state == S_REFILL) && mem_ack;
  assign w_last       = w_ack && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_hit) w_state_nxt = S_REFILL;
      S_REFILL: if (w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (r_state == S_REFILL);
    mem_adr = r_base + {{(30-OFF_W){1'b0}}, r_cnt, 2'b00};
    hit     = w_hit;
    stall   = !w_hit;
    inst    = w_hit ? r_data[w_idx][w_off] : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_valid <= '0;
    end else begin
      if (w_miss_start) begin
        r_base  <= {w_tag, w_idx, {(OFF_W+2){1'b0}}};
        r_idx   <= w_idx;
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end else if (r_state == S_REFILL) begin
        if (inv)   r_abort <= 1'b1;
        if (w_ack) r_cnt   <= r_cnt + 1'b1;
      end
      // inv outranks the final-ack valid set, so an aborted line ends invalid
      if (inv)               r_valid        <= '0;
      else if (w_miss_start) r_valid[w_idx] <= 1'b0;
      else if (w_last)       r_valid[r_idx] <= !r_abort;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ack)  r_data[r_idx][r_cnt] <= mem_rdata;
    if (w_last) r_tag[r_idx]         <= r_base[31:OFF_W+IDX_W+2];
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF))         r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_start && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = 32'h0;
  assign miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (LINES=16, LINE_WORDS=4); memory answers rdata = 0x1111_0000 + adr.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_adr;
  logic [31:0] inst;
  logic        hit;
  logic        stall;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_dly = 0;
  int          cap_n, stall_n, req_n, unstable_n;
  logic [31:0] cap_adr [8];

  always #5 clk = ~clk;

  icache_dm #(.LINES(16), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .inst_adr(inst_adr), .inst(inst), .hit(hit), .stall(stall),
    .inv(inv), .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // memory: ack after ack_dly idle request cycles
  initial begin
    int wcnt;
    wcnt = 0; mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (wcnt == ack_dly) begin
          mem_ack = 1'b1; mem_rdata = 32'h1111_0000 + mem_adr; wcnt = 0;
        end else begin
          mem_ack = 1'b0; wcnt++;
        end
      end else begin
        mem_ack = 1'b0; wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // observe negedges until stall drops, recording ack addresses and request behaviour
  task automatic wait_fill();
    logic prev_req, prev_ack;
    logic [31:0] prev_adr;
    cap_n = 0; stall_n = 0; req_n = 0; unstable_n = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_adr = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_req) begin
        req_n++;
        if (prev_req && !prev_ack && (mem_adr !== prev_adr)) unstable_n++;
        if (mem_ack && cap_n < 8) begin cap_adr[cap_n] = mem_adr; cap_n++; end
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_adr = mem_adr;
      if (stall) stall_n++;
      else break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; inv = 1'b0; inst_adr = 32'h0;
    #3;
    n_tests++;
    if ({mem_req, hit, stall, inst, mem_adr} !== {1'b0, 1'b0, 1'b1, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b hit=%b stall=%b inst=%h adr=%h, want 0 0 1 0 0",
               mem_req, hit, stall, inst, mem_adr);
    end
    n_tests++;
    if ({hit_cnt, miss_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_counters: hit_cnt=%h miss_cnt=%h, want 0 0", hit_cnt, miss_cnt);
    end
    tick(); tick();
  endtask

  task automatic test_fill();
    rst = 1'b1;
    wait_fill();
    n_tests++;
    if (stall_n !== 5) begin n_fail++; $display("FAIL fill_stall: got %0d cycles, want 5", stall_n); end
    n_tests++;
    if (cap_n !== 4) begin n_fail++; $display("FAIL fill_acks: got %0d, want 4", cap_n); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (cap_adr[k] !== 32'(4 * k)) begin
        n_fail++; $display("FAIL fill_adr%0d: got %h, want %h", k, cap_adr[k], 32'(4 * k));
      end
    end
    n_tests++;
    if ({hit, inst, mem_req} !== {1'b1, 32'h1111_0000, 1'b0}) begin
      n_fail++; $display("FAIL fill_hit: hit=%b inst=%h req=%b, want 1 11110000 0", hit, inst, mem_req);
    end
`ifdef ICACHE_STATS_EN
    n_tests++;
    if (miss_cnt !== 32'd1) begin n_fail++; $display("FAIL fill_miss_cnt: got %0d, want 1", miss_cnt); end
`endif
  endtask

  task automatic test_hits();
    for (int k = 1; k < 4; k++) begin
      tick(); inst_adr = 32'(4 * k);
      @(negedge clk);
      n_tests++;
      if ({hit, inst, mem_req} !== {1'b1, 32'h1111_0000 + 32'(4 * k), 1'b0}) begin
        n_fail++;
        $display("FAIL hit_word%0d: hit=%b inst=%h req=%b, want 1 %h 0", k, hit, inst, mem_req,
                 32'h1111_0000 + 32'(4 * k));
      end
    end
    n_tests++;
`ifdef ICACHE_STATS_EN
    if (hit_cnt !== 32'd3) begin n_fail++; $display("FAIL hit_cnt: got %0d, want 3", hit_cnt); end
`else
    if ({hit_cnt, miss_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL stats_off: hit_cnt=%h miss_cnt=%h, want 0 0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_conflict();
    tick(); inst_adr = 32'h100;
    wait_fill();
    n_tests++;
    if (stall_n !== 5 || cap_n !== 4 || cap_adr[0] !== 32'h100 || cap_adr[3] !== 32'h10C) begin
      n_fail++;
      $display("FAIL conflict_fill: stall=%0d acks=%0d first=%h last=%h, want 5 4 100 10c",
               stall_n, cap_n, cap_adr[0], cap_adr[3]);
    end
    n_tests++;
    if (inst !== 32'h1111_0100) begin n_fail++; $display("FAIL conflict_inst: got %h, want 11110100", inst); end
    tick(); inst_adr = 32'h0;
    wait_fill();
    n_tests++;
    if (stall_n !== 5 || inst !== 32'h1111_0000) begin
      n_fail++; $display("FAIL conflict_remiss: stall=%0d inst=%h, want 5 11110000", stall_n, inst);
    end
`ifdef ICACHE_STATS_EN
    n_tests++;
    if (miss_cnt !== 32'd3) begin n_fail++; $display("FAIL conflict_miss_cnt: got %0d, want 3", miss_cnt); end
`endif
  endtask

  task automatic test_ack_delay();
    ack_dly = 3;
    tick(); inst_adr = 32'h40;
    wait_fill();
    n_tests++;
    if (stall_n !== 17) begin n_fail++; $display("FAIL delay_stall: got %0d cycles, want 17", stall_n); end
    n_tests++;
    if (req_n !== 16 || unstable_n !== 0) begin
      n_fail++; $display("FAIL delay_req: req cycles=%0d unstable=%0d, want 16 0", req_n, unstable_n);
    end
    n_tests++;
    if (cap_n !== 4 || cap_adr[1] !== 32'h44 || cap_adr[3] !== 32'h4C || inst !== 32'h1111_0040) begin
      n_fail++;
      $display("FAIL delay_data: acks=%0d adr1=%h adr3=%h inst=%h, want 4 44 4c 11110040",
               cap_n, cap_adr[1], cap_adr[3], inst);
    end
    ack_dly = 0;
  endtask

  task automatic test_inv_idle();
    tick(); inv = 1'b1;
    @(negedge clk);
    n_tests++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL inv_idle_before: hit=%b, want 1", hit); end
    tick(); inv = 1'b0;
    @(negedge clk);
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL inv_idle_after: hit=%b, want 0", hit); end
    wait_fill();
    n_tests++;
    if (hit !== 1'b1 || inst !== 32'h1111_0040) begin
      n_fail++; $display("FAIL inv_idle_refill: hit=%b inst=%h, want 1 11110040", hit, inst);
    end
  endtask

  task automatic test_inv_refill();
    logic found;
    tick(); inst_adr = 32'h80;
    tick(); tick(); inv = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_adr !== 32'h84) begin
      n_fail++; $display("FAIL inv_refill_word2: req=%b adr=%h, want 1 84", mem_req, mem_adr);
    end
    tick(); inv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!mem_req) found = 1'b1;
    end
    n_tests++;
    if (!found || hit !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL inv_refill_remiss: done=%b hit=%b stall=%b, want 1 0 1", found, hit, stall);
    end
    wait_fill();
    n_tests++;
    if (cap_adr[0] !== 32'h80 || inst !== 32'h1111_0080) begin
      n_fail++; $display("FAIL inv_refill_redo: adr0=%h inst=%h, want 80 11110080", cap_adr[0], inst);
    end
    tick(); inst_adr = 32'h40;
    wait_fill();
    n_tests++;
    if (stall_n !== 5) begin n_fail++; $display("FAIL inv_refill_other_idx: stall=%0d, want 5", stall_n); end
`ifdef ICACHE_STATS_EN
    n_tests++;
    if (miss_cnt !== 32'd8) begin n_fail++; $display("FAIL inv_miss_cnt: got %0d, want 8", miss_cnt); end
`endif
  endtask

  task automatic test_reset_refill();
    tick(); inst_adr = 32'hC0;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({mem_req, hit, stall} !== 3'b001 || {hit_cnt, miss_cnt} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid_refill: req=%b hit=%b stall=%b hc=%h mc=%h, want 0 0 1 0 0",
               mem_req, hit, stall, hit_cnt, miss_cnt);
    end
    tick(); rst = 1'b1; inst_adr = 32'h0;
    wait_fill();
    n_tests++;
    if (stall_n !== 5) begin n_fail++; $display("FAIL reset_line0_invalid: stall=%0d, want 5", stall_n); end
    tick(); inst_adr = 32'h40;
    wait_fill();
    n_tests++;
    if (stall_n !== 5 || inst !== 32'h1111_0040) begin
      n_fail++; $display("FAIL reset_line4_invalid: stall=%0d inst=%h, want 5 11110040", stall_n, inst);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hits();
    test_conflict();
    test_ack_delay();
    test_inv_idle();
    test_inv_refill();
    test_reset_refill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
